// File: rtl/avalon_segled_ctrl_if.sv
// Avalon-MM slave bus bundle for the segled controller.
// The master modport is the Nios II side; the slave modport is the IP core.
interface avalon_segled_ctrl_if;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata,
    output avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata,
    input  avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/avalon_segled_ctrl.sv
// Avalon-MM six-digit common-anode 7-segment controller with sequential binary-to-BCD conversion.
// Optional leading-zero blanking is built when SEGLED_LZB_EN is defined.
module avalon_segled_ctrl #(
  parameter int SCAN_CNT = 50000,
  parameter int MAX_VAL  = 999999
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  avalon_segled_ctrl_if.slave         avs,
  output logic [5:0]                  sel,
  output logic [7:0]                  seg_led
);

  localparam int          DIV_W     = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
  localparam logic [19:0] MAX_V     = 20'(MAX_VAL);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Add 3 to every BCD nibble that is 5 or more (double-dabble correction).
  function automatic logic [23:0] bcd_adjust(input logic [23:0] a);
    logic [23:0] r;
    r = a;
    for (int k = 0; k < 6; k++) begin
      if (a[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = a[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = a[4*k +: 4];
      end
    end
    return r;
  endfunction

  // Active-high segment pattern {g,f,e,d,c,b,a}; out-of-range nibbles are blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [19:0]      r_data;
  logic [5:0]       r_point;
  logic             r_en;
  logic [31:0]      r_readdata;
  state_t           r_state;
  logic [19:0]      r_shift;
  logic [23:0]      r_acc;
  logic [4:0]       r_cnt;
  logic [23:0]      r_disp;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_idx;
  logic [5:0]       r_sel;
  logic [7:0]       r_seg;

  logic             w_wr_data;
  logic             w_wr_point;
  logic             w_wr_ctrl;
  logic [19:0]      w_sat;
  logic             w_busy;
  logic             w_en_next;
  logic [23:0]      w_acc_adj;
  logic [3:0]       w_nib;
  logic             w_dp;
  logic [5:0]       w_lz;
  logic [6:0]       w_pat;

  // Bus decode, saturation and conversion helpers.
  always_comb begin
    w_wr_data  = avs.avs_write && (avs.avs_address == 2'd0);
    w_wr_point = avs.avs_write && (avs.avs_address == 2'd1);
    w_wr_ctrl  = avs.avs_write && (avs.avs_address == 2'd2);
    if (avs.avs_writedata[19:0] > MAX_V) begin
      w_sat = MAX_V;
    end else begin
      w_sat = avs.avs_writedata[19:0];
    end
    w_busy    = (r_state != ST_IDLE);
    w_acc_adj = bcd_adjust(r_acc);
    // A CTRL write blanks or restores the display on the same edge it is sampled.
    if (w_wr_ctrl) begin
      w_en_next = avs.avs_writedata[0];
    end else begin
      w_en_next = r_en;
    end
  end

  // Digit selected by the scan index, its dp bit and its leading-zero flag.
  always_comb begin
    case (r_idx)
      3'd0:    begin w_nib = r_disp[3:0];   w_dp = r_point[0]; end
      3'd1:    begin w_nib = r_disp[7:4];   w_dp = r_point[1]; end
      3'd2:    begin w_nib = r_disp[11:8];  w_dp = r_point[2]; end
      3'd3:    begin w_nib = r_disp[15:12]; w_dp = r_point[3]; end
      3'd4:    begin w_nib = r_disp[19:16]; w_dp = r_point[4]; end
      3'd5:    begin w_nib = r_disp[23:20]; w_dp = r_point[5]; end
      default: begin w_nib = 4'hF;          w_dp = 1'b0;       end
    endcase
    w_lz[5] = (r_disp[23:20] == 4'd0);
    w_lz[4] = w_lz[5] && (r_disp[19:16] == 4'd0);
    w_lz[3] = w_lz[4] && (r_disp[15:12] == 4'd0);
    w_lz[2] = w_lz[3] && (r_disp[11:8]  == 4'd0);
    w_lz[1] = w_lz[2] && (r_disp[7:4]   == 4'd0);
    w_lz[0] = 1'b0;
`ifdef SEGLED_LZB_EN
    if ((r_idx <= 3'd5) && w_lz[r_idx]) begin
      w_pat = 7'h00;
    end else begin
      w_pat = seg_decode(w_nib);
    end
`else
    w_pat = seg_decode(w_nib);
`endif
  end

  // Control/status registers and registered read data.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_data     <= 20'h0;
      r_point    <= 6'h0;
      r_en       <= 1'b0;
      r_readdata <= 32'h0;
    end else begin
      if (w_wr_data)  r_data  <= avs.avs_writedata[19:0];
      if (w_wr_point) r_point <= avs.avs_writedata[5:0];
      r_en <= w_en_next;
      if (avs.avs_read) begin
        case (avs.avs_address)
          2'd0:    r_readdata <= {12'h0, r_data};
          2'd1:    r_readdata <= {26'h0, r_point};
          2'd2:    r_readdata <= {31'h0, r_en};
          2'd3:    r_readdata <= {31'h0, w_busy};
          default: r_readdata <= 32'h0;
        endcase
      end
    end
  end

  // Shift-add-3 conversion FSM; a DATA write in any state restarts it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= 20'h0;
      r_acc   <= 24'h0;
      r_cnt   <= 5'd0;
      r_disp  <= 24'h0;
    end else if (w_wr_data) begin
      r_state <= ST_SHIFT;
      r_shift <= w_sat;
      r_acc   <= 24'h0;
      r_cnt   <= 5'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        ST_SHIFT: begin
          {r_acc, r_shift} <= {w_acc_adj[22:0], r_shift, 1'b0};
          r_cnt            <= r_cnt + 5'd1;
          if (r_cnt == 5'd19) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          r_disp  <= r_acc;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Scan divider and digit index; these run regardless of EN.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_div <= '0;
      r_idx <= 3'd0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      if (r_idx >= 3'd5) begin
        r_idx <= 3'd0;
      end else begin
        r_idx <= r_idx + 3'd1;
      end
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // sel and seg_led are registered together so they change on the same edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sel <= 6'h3F;
      r_seg <= 8'hFF;
    end else if (w_en_next && (r_idx <= 3'd5)) begin
      r_sel <= ~(6'd1 << r_idx);
      r_seg <= ~{w_dp, w_pat};
    end else begin
      r_sel <= 6'h3F;
      r_seg <= 8'hFF;
    end
  end

  assign avs.avs_readdata = r_readdata;
  assign sel              = r_sel;
  assign seg_led          = r_seg;

endmodule

// File: tb/tb_avalon_segled_ctrl.sv
// Directed self-checking bench for avalon_segled_ctrl (SCAN_CNT overridden to 4).
module tb_avalon_segled_ctrl;
  logic       clk;
  logic       rst_n;
  logic [5:0] sel;
  logic [7:0] seg_led;
  int         total;
  int         bad;
  logic [31:0] rdv;
  logic        saw_old;

  avalon_segled_ctrl_if bus ();

  avalon_segled_ctrl #(.SCAN_CNT(4), .MAX_VAL(999999)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .avs       (bus.slave),
    .sel       (sel),
    .seg_led   (seg_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Wait (bounded) until digit idx is selected, then compare its segments.
  task automatic chk_digit(input string tag, input int idx, input logic [7:0] exp);
    logic [5:0] tgt;
    logic       found;
    tgt   = ~(6'd1 << idx);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (sel === tgt) found = 1'b1;
    end
    if (found) begin
      chk(tag, {24'h0, seg_led}, {24'h0, exp});
    end else begin
      chk({tag, "_timeout"}, {26'h0, sel}, {26'h0, tgt});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.avs_address   = 2'd0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = 32'h0;
    bus.avs_read      = 1'b0;
    wait_cyc(3);

    // 1: reset state
    chk("rst_sel", {26'h0, sel}, 32'h3F);
    chk("rst_seg", {24'h0, seg_led}, 32'hFF);
    chk("rst_rd", bus.avs_readdata, 32'h0);
    rst_n = 1'b1;
    rd(2'd3, rdv); chk("rst_status", rdv, 32'h0);
    rd(2'd0, rdv); chk("rst_data", rdv, 32'h0);

    // 2: 123456 conversion and scan
    wr(2'd2, 32'd1);
    rd(2'd2, rdv); chk("ctrl_rb", rdv, 32'h1);
    wr(2'd0, 32'd123456);
    rd(2'd3, rdv); chk("busy_1", rdv, 32'h1);
    wait_cyc(23);
    rd(2'd3, rdv); chk("busy_0", rdv, 32'h0);
    rd(2'd0, rdv); chk("data_rb", rdv, 32'd123456);
    chk_digit("d0_6", 0, 8'h82);
    chk_digit("d1_5", 1, 8'h92);
    chk_digit("d2_4", 2, 8'h99);
    chk_digit("d3_3", 3, 8'hB0);
    chk_digit("d4_2", 4, 8'hA4);
    chk_digit("d5_1", 5, 8'hF9);

    // 3: 42, leading digits blank or zero
    wr(2'd0, 32'd42);
    wait_cyc(25);
    chk_digit("v42_d0", 0, 8'hA4);
    chk_digit("v42_d1", 1, 8'h99);
`ifdef SEGLED_LZB_EN
    chk_digit("v42_d2", 2, 8'hFF);
    chk_digit("v42_d5", 5, 8'hFF);
`else
    chk_digit("v42_d2", 2, 8'hC0);
    chk_digit("v42_d5", 5, 8'hC0);
`endif

    // 4: saturation
    wr(2'd0, 32'd1000000);
    wait_cyc(25);
    for (int d = 0; d < 6; d++) chk_digit("sat_dig", d, 8'h90);
    rd(2'd0, rdv); chk("sat_rb", rdv, 32'h000F4240);

    // 5: abort and restart; 111111 must never appear
    saw_old = 1'b0;
    wr(2'd0, 32'd111111);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (seg_led === 8'hF9) saw_old = 1'b1;
    end
    wr(2'd0, 32'd222222);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (seg_led === 8'hF9) saw_old = 1'b1;
    end
    chk("no_partial", {31'h0, saw_old}, 32'h0);
    chk_digit("v2_d0", 0, 8'hA4);
    chk_digit("v2_d3", 3, 8'hA4);
    wr(2'd1, 32'h04);
    rd(2'd1, rdv); chk("point_rb", rdv, 32'h04);
    chk_digit("dp_d2", 2, 8'h24);
    chk_digit("dp_d1", 1, 8'hA4);

    // 6: disable, then reset during SHIFT
    wait_cyc(2);
    wr(2'd2, 32'd0);
    chk("dis_sel", {26'h0, sel}, 32'h3F);
    chk("dis_seg", {24'h0, seg_led}, 32'hFF);
    wr(2'd2, 32'd1);
    chk_digit("reen_d4", 4, 8'hA4);
    wr(2'd0, 32'd555555);
    wait_cyc(3);
    rst_n = 1'b0;
    wait_cyc(2);
    chk("rst2_sel", {26'h0, sel}, 32'h3F);
    rst_n = 1'b1;
    rd(2'd3, rdv); chk("rst2_busy", rdv, 32'h0);
    wr(2'd2, 32'd1);
    chk_digit("z_d0", 0, 8'hC0);
`ifdef SEGLED_LZB_EN
    chk_digit("z_d1", 1, 8'hFF);
    chk_digit("z_d5", 5, 8'hFF);
`else
    chk_digit("z_d1", 1, 8'hC0);
    chk_digit("z_d5", 5, 8'hC0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
